// File: rtl/decode_pkg.sv
// Shared encodings and types for the ARM decode stage (decode_ctrl, decode_pipe).
package decode_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0110;
  localparam logic [3:0] ALU_RSB = 4'b1001;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef enum logic {S_ONE = 1'b0, S_SECOND = 1'b1} state_t;

  typedef struct packed {
    logic       uop;
    logic       pcs;
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       no_write;
    logic       ig_rn;
    logic       off_zero;
    logic       undef;
    logic [1:0] imm_src;
    logic [1:0] flag_w;
    logic [3:0] alu_ctrl;
    logic [3:0] wa3;
  } ctrl_t;

endpackage

// File: rtl/decode_pipe_if.sv
// D/E boundary bundle for decode_pipe; perf counters exist only with DECODE_PERF_CNT_EN.
interface decode_pipe_if #(
  parameter int ALU_CTRL_W = 4,
  parameter int REG_AW     = 4,
  parameter int CNT_W      = 16
);
  logic [31:0]           InstrD;
  logic                  ValidD;
  logic                  StallD;
  logic                  FlushD;
  logic                  FlushE;
  logic                  BusyD;
  logic [1:0]            RegSrcD;
  logic                  ValidE;
  logic                  UopE;
  logic                  PCSE, RegWE, MemWE, MemtoRegE, ALUSrcE;
  logic                  BranchE, NoWriteE, IgRnE, OffZeroE, UndefE;
  logic [1:0]            ImmSrcE;
  logic [1:0]            FlagWE;
  logic [ALU_CTRL_W-1:0] ALUControlE;
  logic [REG_AW-1:0]     WA3E;
`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0]      UopCnt;
  logic [CNT_W-1:0]      StallCnt;
`endif

  modport master (
    output InstrD, ValidD, StallD, FlushD, FlushE,
    input  BusyD, RegSrcD, ValidE, UopE, PCSE, RegWE, MemWE, MemtoRegE, ALUSrcE,
           BranchE, NoWriteE, IgRnE, OffZeroE, UndefE, ImmSrcE, FlagWE, ALUControlE, WA3E
`ifdef DECODE_PERF_CNT_EN
    , input UopCnt, StallCnt
`endif
  );

  modport slave (
    input  InstrD, ValidD, StallD, FlushD, FlushE,
    output BusyD, RegSrcD, ValidE, UopE, PCSE, RegWE, MemWE, MemtoRegE, ALUSrcE,
           BranchE, NoWriteE, IgRnE, OffZeroE, UndefE, ImmSrcE, FlagWE, ALUControlE, WA3E
`ifdef DECODE_PERF_CNT_EN
    , output UopCnt, StallCnt
`endif
  );
endinterface

// File: rtl/decode_ctrl.sv
// Combinational ARM instruction decoder: instruction fields -> control bundle.
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [15:0] instr_hi,
  output ctrl_t       ctrl,
  output logic [1:0]  reg_src,
  output logic        split
);
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;

  assign op    = instr_hi[15:14];
  assign funct = instr_hi[13:8];
  assign cmd   = funct[4:1];

  always_comb begin
    ctrl     = '0;
    reg_src  = 2'b00;
    split    = 1'b0;
    ctrl.wa3 = instr_hi[3:0];
    case (op)
      OP_DP: begin
        ctrl.reg_w   = 1'b1;
        ctrl.alu_src = funct[5];
        case (cmd)
          4'b0000: ctrl.alu_ctrl = ALU_AND;
          4'b0001: ctrl.alu_ctrl = ALU_EOR;
          4'b0010: ctrl.alu_ctrl = ALU_SUB;
          4'b0011: ctrl.alu_ctrl = ALU_RSB;
          4'b0100: ctrl.alu_ctrl = ALU_ADD;
          4'b1000: begin ctrl.alu_ctrl = ALU_AND; ctrl.no_write = 1'b1; end
          4'b1001: begin ctrl.alu_ctrl = ALU_EOR; ctrl.no_write = 1'b1; end
          4'b1010: begin ctrl.alu_ctrl = ALU_SUB; ctrl.no_write = 1'b1; end
          4'b1011: begin ctrl.alu_ctrl = ALU_ADD; ctrl.no_write = 1'b1; end
          4'b1100: ctrl.alu_ctrl = ALU_ORR;
          4'b1101: begin ctrl.alu_ctrl = ALU_ADD; ctrl.ig_rn = 1'b1; end
          default: ctrl.undef = 1'b1;
        endcase
        if (ctrl.undef) begin
          ctrl.reg_w    = 1'b0;
          ctrl.no_write = 1'b1;
        end else begin
          ctrl.flag_w = {funct[0], funct[0] & ((ctrl.alu_ctrl == ALU_ADD) | (ctrl.alu_ctrl == ALU_SUB))};
        end
      end
      OP_MEM: begin
        ctrl.alu_src  = ~funct[5];
        ctrl.imm_src  = 2'b01;
        ctrl.alu_ctrl = funct[3] ? ALU_ADD : ALU_SUB;
        // Post-indexed accesses address memory with the bare base register
        ctrl.off_zero = ~funct[4];
        split         = ~funct[4] | funct[1];
        if (funct[0]) begin
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_w      = 1'b1;
        end else begin
          ctrl.mem_w = 1'b1;
          reg_src    = 2'b10;
        end
      end
      OP_BR: begin
        reg_src        = 2'b01;
        ctrl.imm_src   = 2'b10;
        ctrl.alu_src   = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      default: begin
        ctrl.undef    = 1'b1;
        ctrl.no_write = 1'b1;
      end
    endcase
    ctrl.pcs = ((ctrl.wa3 == 4'hF) & ctrl.reg_w) | ctrl.branch;
  end
endmodule

// File: rtl/decode_pipe.sv
// ARM decode stage: decoder, writeback micro-sequencer and registered D->E controls.
// Optional build macro DECODE_PERF_CNT_EN adds saturating UopCnt/StallCnt counters.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int REG_AW     = 4,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          reset,
  decode_pipe_if.slave  bus
);
  ctrl_t      dec_p0, uop1_p0, issue_p0, ctrl_p1;
  logic [1:0] reg_src_p0;
  logic       split_p0;
  logic       issue_vld_p0, vld_p1;
  state_t     state_p1;
  logic       unused_bits;

  assign unused_bits = ^{bus.InstrD[31:28], bus.InstrD[11:0]};

  decode_ctrl u_ctrl (
    .instr_hi (bus.InstrD[27:12]),
    .ctrl     (dec_p0),
    .reg_src  (reg_src_p0),
    .split    (split_p0)
  );

  // Second micro-op: base-register update Rn <= Rn +/- offset
  always_comb begin
    uop1_p0          = '0;
    uop1_p0.uop      = 1'b1;
    uop1_p0.reg_w    = 1'b1;
    uop1_p0.alu_src  = ~bus.InstrD[25];
    uop1_p0.imm_src  = 2'b01;
    uop1_p0.alu_ctrl = bus.InstrD[23] ? ALU_ADD : ALU_SUB;
    uop1_p0.wa3      = bus.InstrD[19:16];
    uop1_p0.pcs      = (bus.InstrD[19:16] == 4'hF);
  end

  assign issue_p0     = (state_p1 == S_SECOND) ? uop1_p0 : dec_p0;
  assign issue_vld_p0 = ~bus.FlushD & ((state_p1 == S_SECOND) | bus.ValidD);
  assign bus.BusyD    = (state_p1 == S_ONE) & bus.ValidD & split_p0 & ~bus.StallD & ~bus.FlushD;
  assign bus.RegSrcD  = (state_p1 == S_SECOND) ? 2'b00 : reg_src_p0;

  // D -> E register and micro-sequencer state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1 <= S_ONE;
      vld_p1   <= 1'b0;
      ctrl_p1  <= '0;
    end else begin
      if (bus.FlushD)
        state_p1 <= S_ONE;
      else if (!bus.StallD)
        state_p1 <= (state_p1 == S_ONE && bus.ValidD && split_p0) ? S_SECOND : S_ONE;

      if (bus.FlushE) begin
        vld_p1  <= 1'b0;
        ctrl_p1 <= '0;
      end else if (!bus.StallD) begin
        vld_p1  <= issue_vld_p0;
        ctrl_p1 <= issue_vld_p0 ? issue_p0 : '0;
      end
    end
  end

  assign bus.ValidE      = vld_p1;
  assign bus.UopE        = ctrl_p1.uop;
  assign bus.PCSE        = ctrl_p1.pcs;
  assign bus.RegWE       = ctrl_p1.reg_w;
  assign bus.MemWE       = ctrl_p1.mem_w;
  assign bus.MemtoRegE   = ctrl_p1.mem_to_reg;
  assign bus.ALUSrcE     = ctrl_p1.alu_src;
  assign bus.BranchE     = ctrl_p1.branch;
  assign bus.NoWriteE    = ctrl_p1.no_write;
  assign bus.IgRnE       = ctrl_p1.ig_rn;
  assign bus.OffZeroE    = ctrl_p1.off_zero;
  assign bus.UndefE      = ctrl_p1.undef;
  assign bus.ImmSrcE     = ctrl_p1.imm_src;
  assign bus.FlagWE      = ctrl_p1.flag_w;
  assign bus.ALUControlE = ALU_CTRL_W'(ctrl_p1.alu_ctrl);
  assign bus.WA3E        = REG_AW'(ctrl_p1.wa3);

`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] uop_cnt_p1, stall_cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      uop_cnt_p1   <= '0;
      stall_cnt_p1 <= '0;
    end else begin
      if (!bus.FlushE && !bus.StallD && issue_vld_p0) uop_cnt_p1 <= sat_inc(uop_cnt_p1);
      if (bus.StallD) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign bus.UopCnt   = uop_cnt_p1;
  assign bus.StallCnt = stall_cnt_p1;
`else
  localparam int UNUSED_CNT_W = CNT_W;
`endif
endmodule

// File: tb/tb_decode_pipe.sv
// Directed self-checking bench for decode_pipe with hand-computed expectations.
module tb_decode_pipe;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  decode_pipe_if ifc ();
  decode_pipe dut (.clk(clk), .reset(reset), .bus(ifc.slave));

  task automatic drive(input logic [31:0] instr, input logic v, input logic st,
                       input logic fd, input logic fe);
    ifc.InstrD = instr; ifc.ValidD = v; ifc.StallD = st; ifc.FlushD = fd; ifc.FlushE = fe;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    n_cmp++; if (ifc.ValidE !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", ifc.ValidE); end
    n_cmp++; if ({ifc.RegWE, ifc.MemWE, ifc.PCSE, ifc.UopE} !== 4'b0) begin n_err++; $display("FAIL rst_ctrl: got %b want 0000", {ifc.RegWE, ifc.MemWE, ifc.PCSE, ifc.UopE}); end
    n_cmp++; if (ifc.BusyD !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", ifc.BusyD); end
    reset = 1'b0;
  endtask

  task automatic test_dp();
    // ADDS R1,R2,#4
    drive(32'hE2921004, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ifc.BusyD !== 1'b0) begin n_err++; $display("FAIL adds_busy: got %b want 0", ifc.BusyD); end
    tick();
    n_cmp++; if ({ifc.ValidE, ifc.RegWE, ifc.ALUSrcE, ifc.NoWriteE} !== 4'b1110) begin n_err++; $display("FAIL adds_ctrl: got %b want 1110", {ifc.ValidE, ifc.RegWE, ifc.ALUSrcE, ifc.NoWriteE}); end
    n_cmp++; if ({ifc.ALUControlE, ifc.FlagWE, ifc.WA3E} !== {4'b0000, 2'b11, 4'd1}) begin n_err++; $display("FAIL adds_fields: got %h want %h", {ifc.ALUControlE, ifc.FlagWE, ifc.WA3E}, {4'b0000, 2'b11, 4'd1}); end
    // CMP R3,R4
    drive(32'hE1530004, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if ({ifc.NoWriteE, ifc.ALUSrcE, ifc.ALUControlE, ifc.FlagWE} !== {1'b1, 1'b0, 4'b0001, 2'b11}) begin n_err++; $display("FAIL cmp_ctrl: got %b want 10000111", {ifc.NoWriteE, ifc.ALUSrcE, ifc.ALUControlE, ifc.FlagWE}); end
    // MOV PC,R0
    drive(32'hE1A0F000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if ({ifc.PCSE, ifc.IgRnE, ifc.RegWE, ifc.FlagWE, ifc.ALUControlE, ifc.WA3E} !== {3'b111, 2'b00, 4'b0000, 4'hF}) begin n_err++; $display("FAIL mov_pc: got %b want 11100_0000_1111", {ifc.PCSE, ifc.IgRnE, ifc.RegWE, ifc.FlagWE, ifc.ALUControlE, ifc.WA3E}); end
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (ifc.ValidE !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", ifc.ValidE); end
  endtask

  task automatic test_undef();
    drive(32'hEC123456, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if ({ifc.ValidE, ifc.UndefE, ifc.NoWriteE, ifc.RegWE, ifc.MemWE, ifc.BranchE, ifc.PCSE, ifc.FlagWE} !== 9'b111000000) begin n_err++; $display("FAIL undef_op11: got %b want 111000000", {ifc.ValidE, ifc.UndefE, ifc.NoWriteE, ifc.RegWE, ifc.MemWE, ifc.BranchE, ifc.PCSE, ifc.FlagWE}); end
    // Unlisted DP code 0101
    drive(32'hE0A21003, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if ({ifc.UndefE, ifc.NoWriteE, ifc.RegWE, ifc.FlagWE} !== 5'b11000) begin n_err++; $display("FAIL undef_dp: got %b want 11000", {ifc.UndefE, ifc.NoWriteE, ifc.RegWE, ifc.FlagWE}); end
  endtask

  task automatic test_branch_store();
    drive(32'hEA000010, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ifc.RegSrcD !== 2'b01) begin n_err++; $display("FAIL br_regsrc: got %b want 01", ifc.RegSrcD); end
    tick();
    n_cmp++; if ({ifc.BranchE, ifc.PCSE, ifc.ALUSrcE, ifc.ImmSrcE, ifc.RegWE} !== 6'b111100) begin n_err++; $display("FAIL br_ctrl: got %b want 111100", {ifc.BranchE, ifc.PCSE, ifc.ALUSrcE, ifc.ImmSrcE, ifc.RegWE}); end
    // STR R2,[R3] : offset addressing, no writeback
    drive(32'hE5832000, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({ifc.RegSrcD, ifc.BusyD} !== 3'b100) begin n_err++; $display("FAIL str_d: got %b want 100", {ifc.RegSrcD, ifc.BusyD}); end
    tick();
    n_cmp++; if ({ifc.MemWE, ifc.RegWE, ifc.ImmSrcE, ifc.ALUControlE, ifc.OffZeroE} !== {2'b10, 2'b01, 4'b0000, 1'b0}) begin n_err++; $display("FAIL str_e: got %b want 10010_0000_0", {ifc.MemWE, ifc.RegWE, ifc.ImmSrcE, ifc.ALUControlE, ifc.OffZeroE}); end
  endtask

  task automatic test_split_ldr();
    // LDR R0,[R1],#8
    drive(32'hE4910008, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ifc.BusyD !== 1'b1) begin n_err++; $display("FAIL ldr_busy1: got %b want 1", ifc.BusyD); end
    tick();
    n_cmp++; if ({ifc.ValidE, ifc.UopE, ifc.MemtoRegE, ifc.OffZeroE, ifc.RegWE, ifc.WA3E} !== {5'b10111, 4'd0}) begin n_err++; $display("FAIL ldr_uop0: got %b want 10111_0000", {ifc.ValidE, ifc.UopE, ifc.MemtoRegE, ifc.OffZeroE, ifc.RegWE, ifc.WA3E}); end
    n_cmp++; if (ifc.BusyD !== 1'b0) begin n_err++; $display("FAIL ldr_busy2: got %b want 0", ifc.BusyD); end
    tick();
    n_cmp++; if ({ifc.ValidE, ifc.UopE, ifc.RegWE, ifc.MemWE, ifc.MemtoRegE, ifc.ALUSrcE, ifc.FlagWE} !== 8'b11100100) begin n_err++; $display("FAIL ldr_uop1_ctrl: got %b want 11100100", {ifc.ValidE, ifc.UopE, ifc.RegWE, ifc.MemWE, ifc.MemtoRegE, ifc.ALUSrcE, ifc.FlagWE}); end
    n_cmp++; if ({ifc.WA3E, ifc.ALUControlE} !== {4'd1, 4'b0000}) begin n_err++; $display("FAIL ldr_uop1_fld: got %h want 10", {ifc.WA3E, ifc.ALUControlE}); end
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_flush_split();
    // STR R2,[R3,#-4]!
    drive(32'hE5232004, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ifc.BusyD !== 1'b1) begin n_err++; $display("FAIL strw_busy: got %b want 1", ifc.BusyD); end
    tick();
    n_cmp++; if ({ifc.MemWE, ifc.RegWE, ifc.OffZeroE, ifc.ALUControlE} !== {3'b100, 4'b0001}) begin n_err++; $display("FAIL strw_uop0: got %b want 100_0001", {ifc.MemWE, ifc.RegWE, ifc.OffZeroE, ifc.ALUControlE}); end
    drive(32'hE5232004, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    n_cmp++; if ({ifc.ValidE, ifc.UopE, ifc.RegWE} !== 3'b000) begin n_err++; $display("FAIL strw_flush: got %b want 000", {ifc.ValidE, ifc.UopE, ifc.RegWE}); end
    // Back in S_ONE: a fresh ADDS issues as a first micro-op to Rd
    drive(32'hE2921004, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if ({ifc.ValidE, ifc.UopE, ifc.WA3E} !== {2'b10, 4'd1}) begin n_err++; $display("FAIL strw_state: got %b want 10_0001", {ifc.ValidE, ifc.UopE, ifc.WA3E}); end
  endtask

  task automatic test_stall_flushe();
    drive(32'hE4910008, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'hE4910008, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    n_cmp++; if ({ifc.ValidE, ifc.RegWE, ifc.MemtoRegE} !== 3'b000) begin n_err++; $display("FAIL sfe_bubble: got %b want 000", {ifc.ValidE, ifc.RegWE, ifc.MemtoRegE}); end
    drive(32'hE4910008, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++; if (ifc.ValidE !== 1'b0) begin n_err++; $display("FAIL sfe_hold: got %b want 0", ifc.ValidE); end
    drive(32'hE4910008, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if ({ifc.ValidE, ifc.UopE, ifc.WA3E} !== {2'b11, 4'd1}) begin n_err++; $display("FAIL sfe_uop1: got %b want 11_0001", {ifc.ValidE, ifc.UopE, ifc.WA3E}); end
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_stall_hold();
    drive(32'hE2921004, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'hE1530004, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    n_cmp++; if ({ifc.ValidE, ifc.NoWriteE, ifc.ALUControlE, ifc.WA3E} !== {2'b10, 4'b0000, 4'd1}) begin n_err++; $display("FAIL stall_hold: got %b want 10_0000_0001", {ifc.ValidE, ifc.NoWriteE, ifc.ALUControlE, ifc.WA3E}); end
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_split();
    drive(32'hE4910008, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if ({ifc.ValidE, ifc.UopE, ifc.RegWE, ifc.ALUControlE, ifc.WA3E} !== 11'b0) begin n_err++; $display("FAIL rstmid_e: got %b want 0", {ifc.ValidE, ifc.UopE, ifc.RegWE, ifc.ALUControlE, ifc.WA3E}); end
    reset = 1'b0;
    #1;
    n_cmp++; if (ifc.BusyD !== 1'b1) begin n_err++; $display("FAIL rstmid_state: got BusyD %b want 1", ifc.BusyD); end
    tick();
    n_cmp++; if ({ifc.ValidE, ifc.UopE, ifc.MemtoRegE} !== 3'b101) begin n_err++; $display("FAIL rstmid_uop0: got %b want 101", {ifc.ValidE, ifc.UopE, ifc.MemtoRegE}); end
    drive(32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_dp();
    test_undef();
    test_branch_store();
    test_split_ldr();
    test_flush_split();
    test_stall_flushe();
    test_stall_hold();
    test_reset_mid_split();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
